// File: rtl/mux_scan_collector_pkg.sv
// Shared definitions for the mux scan collector: FSM state encoding and settle-counter width.
package mux_scan_collector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam int SETTLE_CNT_W = 4;

endpackage

// File: rtl/mux_scan_settle_timer.sv
// Loadable down-counter; done is high while the count has reached zero.
module mux_scan_settle_timer
    import mux_scan_collector_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [SETTLE_CNT_W-1:0] load_val,
    input  logic                    dec,
    output logic                    done
);

    logic [SETTLE_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_collector.sv
// Scans a single-bit pad mux channel by channel and presents the snapshot on valid/ready.
// Optional MUX_SCAN_PARITY_EN adds parity_o, the XOR of all sampled bits.
module mux_scan_collector
    import mux_scan_collector_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int LOG_WIDTH = 5,
    parameter int SETTLE    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 cont_i,
    input  logic                 abort_i,
    output logic [LOG_WIDTH-1:0] sel_o,
    input  logic                 bit_i,
    output logic [WIDTH-1:0]     word_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 busy_o,
    output state_t               state_o
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic                 parity_o
`endif
);

    // Handshake: word_o is transferred in any cycle where valid_o && ready_i; once raised,
    // valid_o and word_o hold until that transfer (or an abort/reset) takes place.

    localparam logic [LOG_WIDTH-1:0] SEL_LAST = LOG_WIDTH'(WIDTH - 1);
    localparam int SETTLE_LOAD_I = (SETTLE == 0) ? 0 : SETTLE - 1;
    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE_LOAD_I);
    localparam state_t FIRST_ST = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

    state_t               state_q, state_n;
    logic [LOG_WIDTH-1:0] sel_n;
    logic [WIDTH-1:0]     word_n;
    logic                 valid_n;
    logic                 timer_load, timer_dec, timer_done;
`ifdef MUX_SCAN_PARITY_EN
    logic                 par_q, par_n;
`endif

    mux_scan_settle_timer u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (SETTLE_LOAD),
        .dec      (timer_dec),
        .done     (timer_done)
    );

    always_comb begin
        state_n    = state_q;
        sel_n      = sel_o;
        word_n     = word_o;
        valid_n    = valid_o;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
`ifdef MUX_SCAN_PARITY_EN
        par_n      = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    sel_n      = '0;
                    word_n     = '0;
                    state_n    = FIRST_ST;
                    timer_load = 1'b1;
`ifdef MUX_SCAN_PARITY_EN
                    par_n      = 1'b0;
`endif
                end
            end
            ST_SETTLE: begin
                if (timer_done) state_n = ST_SAMPLE;
                else            timer_dec = 1'b1;
            end
            ST_SAMPLE: begin
                word_n[sel_o] = bit_i;
`ifdef MUX_SCAN_PARITY_EN
                par_n = par_q ^ bit_i;
`endif
                if (sel_o == SEL_LAST) begin
                    state_n = ST_HOLD;
                    valid_n = 1'b1;
                end else begin
                    sel_n = sel_o + 1'b1;
                    // With no settle time the FSM stays in SAMPLE, one channel per cycle.
                    if (SETTLE != 0) begin
                        state_n    = ST_SETTLE;
                        timer_load = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (valid_o && ready_i) begin
                    valid_n = 1'b0;
                    if (cont_i) begin
                        sel_n      = '0;
                        word_n     = '0;
                        state_n    = FIRST_ST;
                        timer_load = 1'b1;
`ifdef MUX_SCAN_PARITY_EN
                        par_n      = 1'b0;
`endif
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Abort overrides everything, including a continuous restart; word_o keeps its value.
        if (abort_i) begin
            state_n    = ST_IDLE;
            valid_n    = 1'b0;
            sel_n      = '0;
            word_n     = word_o;
            timer_load = 1'b0;
            timer_dec  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_o   <= '0;
            word_o  <= '0;
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            sel_o   <= sel_n;
            word_o  <= word_n;
            valid_o <= valid_n;
            busy_o  <= (state_n != ST_IDLE);
`ifdef MUX_SCAN_PARITY_EN
            par_q   <= par_n;
`endif
        end
    end

    assign state_o = state_q;
`ifdef MUX_SCAN_PARITY_EN
    assign parity_o = par_q;
`endif

endmodule

// File: tb/tb_mux_scan_collector.sv
// Randomized scoreboard bench for mux_scan_collector (default and WIDTH=20/SETTLE=0 instances).
module tb_mux_scan_collector;
    import mux_scan_collector_pkg::*;

    localparam int W     = 32;
    localparam int LW    = 5;
    localparam int S     = 1;
    localparam int LAT   = W * (S + 1) + 1;
    localparam int WB    = 20;
    localparam int SB    = 0;
    localparam int LAT_B = WB * (SB + 1) + 1;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // instance A: default parameters
    logic          start_i = 1'b0, cont_i = 1'b0, abort_i = 1'b0, ready_i = 1'b0;
    logic [LW-1:0] sel_o;
    logic [W-1:0]  word_o;
    logic          valid_o, busy_o, bit_i;
    state_t        state_o;
    logic [W-1:0]  pat = '0;
    assign bit_i = pat[sel_o];
`ifdef MUX_SCAN_PARITY_EN
    logic          parity_o;
`endif

    // instance B: WIDTH=20, SETTLE=0
    logic          start_b = 1'b0, ready_b = 1'b0;
    logic [LW-1:0] sel_b;
    logic [WB-1:0] word_b;
    logic          valid_b, busy_b, bit_b;
    state_t        state_b;
    logic [WB-1:0] pat_b = '0;
    assign bit_b = pat_b[sel_b];
`ifdef MUX_SCAN_PARITY_EN
    logic          parity_b;
`endif

    mux_scan_collector #(.WIDTH(W), .LOG_WIDTH(LW), .SETTLE(S)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .cont_i  (cont_i),
        .abort_i (abort_i),
        .sel_o   (sel_o),
        .bit_i   (bit_i),
        .word_o  (word_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .busy_o  (busy_o),
        .state_o (state_o)
`ifdef MUX_SCAN_PARITY_EN
        ,
        .parity_o(parity_o)
`endif
    );

    mux_scan_collector #(.WIDTH(WB), .LOG_WIDTH(LW), .SETTLE(SB)) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_b),
        .cont_i  (1'b0),
        .abort_i (1'b0),
        .sel_o   (sel_b),
        .bit_i   (bit_b),
        .word_o  (word_b),
        .valid_o (valid_b),
        .ready_i (ready_b),
        .busy_o  (busy_b),
        .state_o (state_b)
`ifdef MUX_SCAN_PARITY_EN
        ,
        .parity_o(parity_b)
`endif
    );

    // scoreboard
    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0]  exp_q[$];
    int            rise_q[$];
    logic [WB-1:0] exp_b_q[$];
    int            rise_b_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // monitor A: valid rise timing and word at each handshake
    bit           prev_v = 1'b0;
    int           mon_c;
    logic [W-1:0] mon_w;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (valid_o && !prev_v) begin
                mon_c = (rise_q.size() > 0) ? rise_q.pop_front() : -1;
                check("valid_rise_cycle", cyc, mon_c);
            end
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    flag("unexpected_handshake");
                end else begin
                    mon_w = exp_q.pop_front();
                    check("word", word_o, mon_w);
`ifdef MUX_SCAN_PARITY_EN
                    check("parity", parity_o, ^mon_w);
`endif
                end
            end
            prev_v = valid_o;
        end
    end

    // monitor B
    bit            prev_vb = 1'b0;
    int            mon_cb;
    logic [WB-1:0] mon_wb;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_vb = 1'b0;
        end else begin
            if (valid_b && !prev_vb) begin
                mon_cb = (rise_b_q.size() > 0) ? rise_b_q.pop_front() : -1;
                check("b_valid_rise_cycle", cyc, mon_cb);
            end
            if (valid_b && ready_b) begin
                if (exp_b_q.size() == 0) begin
                    flag("b_unexpected_handshake");
                end else begin
                    mon_wb = exp_b_q.pop_front();
                    check("b_word", word_b, mon_wb);
`ifdef MUX_SCAN_PARITY_EN
                    check("b_parity", parity_b, ^mon_wb);
`endif
                end
            end
            prev_vb = valid_b;
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [W-1:0] p, input bit push);
        pat     = p;
        start_i = 1'b1;
        if (push) begin
            exp_q.push_back(p);
            rise_q.push_back(cyc + LAT);
        end
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < LAT + 5; i++) begin
            if (valid_o) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
        flag("timeout_waiting_valid");
    endtask

    task automatic wait_handshake(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < LAT + 5; i++) begin
            @(negedge clk);
            if (valid_o && ready_i) begin
                ok = 1'b1;
                return;
            end
        end
        flag("timeout_waiting_handshake");
    endtask

    task automatic scan_single(input logic [W-1:0] p, input int hold);
        bit ok;
        ready_i = 1'b0;
        do_start(p, 1'b1);
        wait_valid(ok);
        if (ok) begin
            for (int i = 0; i < hold; i++) begin
                check("hold_valid", valid_o, 1'b1);
                check("hold_word", word_o, p);
                check("hold_sel", sel_o, W - 1);
                tick();
            end
            ready_i = 1'b1;
            tick();
            ready_i = 1'b0;
            check("post_valid", valid_o, 1'b0);
            check("post_state", state_o, ST_IDLE);
            check("post_busy", busy_o, 1'b0);
        end
    endtask

    task automatic cont_run(input int n);
        bit           ok;
        logic [W-1:0] np;
        cont_i  = 1'b1;
        ready_i = 1'b1;
        do_start($urandom, 1'b1);
        for (int k = 0; k < n; k++) begin
            cont_i = (k < n - 1);
            wait_handshake(ok);
            if (!ok) break;
            np = $urandom;
            if (k < n - 1) begin
                exp_q.push_back(np);
                rise_q.push_back(cyc + LAT);
            end
            tick();
            if (k < n - 1) begin
                pat = np;
                check("cont_restart_state", state_o, ST_SETTLE);
                check("cont_restart_sel", sel_o, 0);
                check("cont_restart_valid", valid_o, 1'b0);
            end else begin
                check("cont_end_state", state_o, ST_IDLE);
            end
        end
        cont_i  = 1'b0;
        ready_i = 1'b0;
    endtask

    task automatic abort_test();
        logic [W-1:0] p;
        int           vcnt;
        bit           hit;
        p   = $urandom | 32'h0001_FFFF;
        hit = 1'b0;
        ready_i = 1'b1;
        do_start(p, 1'b0);
        for (int i = 0; i < LAT; i++) begin
            if (sel_o == LW'(17)) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        check("abort_reached_sel17", hit, 1'b1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("abort_state", state_o, ST_IDLE);
        check("abort_sel", sel_o, 0);
        check("abort_busy", busy_o, 1'b0);
        check("abort_word_kept", word_o, p & 32'h0001_FFFF);
        vcnt = 0;
        for (int i = 0; i < LAT + 10; i++) begin
            if (valid_o) vcnt++;
            tick();
        end
        check("abort_no_valid", vcnt, 0);
        start_i = 1'b1;
        abort_i = 1'b1;
        tick();
        start_i = 1'b0;
        abort_i = 1'b0;
        check("start_abort_state", state_o, ST_IDLE);
        tick();
        check("start_abort_busy", busy_o, 1'b0);
        ready_i = 1'b0;
    endtask

    task automatic b_scan(input logic [WB-1:0] p);
        int max_sel;
        bit seen;
        max_sel = 0;
        seen    = 1'b0;
        pat_b   = p;
        ready_b = 1'b1;
        start_b = 1'b1;
        exp_b_q.push_back(p);
        rise_b_q.push_back(cyc + LAT_B);
        tick();
        start_b = 1'b0;
        for (int i = 0; i < LAT_B + 5; i++) begin
            if (int'(sel_b) > max_sel) max_sel = int'(sel_b);
            if (valid_b) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("b_valid_seen", seen, 1'b1);
        check("b_sel_max", max_sel, WB - 1);
        tick();
        ready_b = 1'b0;
        check("b_idle", state_b, ST_IDLE);
    endtask

    task automatic reset_test();
        do_start(32'hFFFF_FFFF, 1'b0);
        repeat (20) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_word", word_o, 0);
        check("rst_sel", sel_o, 0);
        check("rst_valid", valid_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_state", state_o, ST_IDLE);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("rst_released_state", state_o, ST_IDLE);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout (cycle %0d)", cyc);
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_sel", sel_o, 0);
        check("reset_word", word_o, 0);
        check("reset_valid", valid_o, 1'b0);
        check("reset_busy", busy_o, 1'b0);
        check("reset_state", state_o, ST_IDLE);
        check("reset_b_valid", valid_b, 1'b0);
        rst_n = 1'b1;
        tick();
        check("idle_after_reset", state_o, ST_IDLE);

        scan_single(32'hA5C3_0F96, 10);
        scan_single(32'h0000_0007, 0);
        for (int i = 0; i < 3; i++) scan_single($urandom, $urandom_range(0, 5));
        cont_run(3);
        abort_test();
        scan_single($urandom, 1);
        b_scan(20'hA_5C3F);
        b_scan(WB'($urandom));
        reset_test();
        scan_single($urandom, 2);
        b_scan(WB'($urandom));

        repeat (5) tick();
        check("exp_q_drained", exp_q.size(), 0);
        check("rise_q_drained", rise_q.size(), 0);
        check("exp_b_q_drained", exp_b_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
